// File: rtl/nebula_traffic_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | nebula_traffic_gen: multi-flit packet injector on a valid/ready link.  |
// | out_flit = {head, tail, vclass, dst_x, dst_y, payload}                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module nebula_traffic_gen #(
  parameter int VCS            = 2,
  parameter int PKT_LEN_MAX    = 16,
  parameter int MESH_X         = 4,
  parameter int MESH_Y         = 4,
  parameter int FLIT_PAYLOAD_W = 32,
  localparam int VC_W          = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int LEN_W         = $clog2(PKT_LEN_MAX + 1),
  localparam int HDR_W         = 2 + VC_W + 16,
  localparam int FLIT_W        = HDR_W + FLIT_PAYLOAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       cfg_num_pkts,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [7:0]        cfg_gap,
  input  logic [VC_W-1:0]   cfg_vclass,
  input  logic [7:0]        cfg_dst_x,
  input  logic [7:0]        cfg_dst_y,
  input  logic              cfg_sweep,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pkts_sent,
  output logic [31:0]       flits_sent
);

  typedef struct packed {
    logic            head;
    logic            tail;
    logic [VC_W-1:0] vclass;
    logic [7:0]      dst_x;
    logic [7:0]      dst_y;
  } flit_hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PKT_LEN_MAX);
  localparam logic [7:0]       MX      = 8'(MESH_X);
  localparam logic [7:0]       MY      = 8'(MESH_Y);

  state_t           state, state_next;
  logic [15:0]      num_pkts;
  logic [LEN_W-1:0] len;
  logic [7:0]       gap;
  logic [VC_W-1:0]  vclass;
  logic             sweep;
  logic [7:0]       cur_x, cur_y;
  logic [LEN_W-1:0] flit_idx;
  logic [15:0]      pkt_id;
  logic [7:0]       gap_cnt;
  logic             stop_seen;

  logic             handshake;
  logic             is_tail;
  logic             last_pkt;
  logic [31:0]      pkts_inc;
  logic [LEN_W-1:0] len_eff;
  flit_hdr_t        hdr;

  assign handshake = out_valid & out_ready;
  assign is_tail   = (flit_idx == len - LEN_ONE);
  assign pkts_inc  = (pkts_sent == 32'hFFFF_FFFF) ? pkts_sent : pkts_sent + 32'd1;
  assign last_pkt  = (num_pkts != 16'd0) && (pkts_inc == {16'd0, num_pkts});
  assign len_eff   = (cfg_pkt_len == '0)     ? LEN_ONE :
                     (cfg_pkt_len > LEN_MAX) ? LEN_MAX : cfg_pkt_len;

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND) || (state == GAP);
  assign done      = (state == DONE);

  always_comb begin
    hdr.head   = (flit_idx == '0);
    hdr.tail   = is_tail;
    hdr.vclass = vclass;
    hdr.dst_x  = cur_x;
    hdr.dst_y  = cur_y;
  end

  assign out_flit = out_valid ?
      {hdr, {(FLIT_PAYLOAD_W-24){1'b0}}, 8'(flit_idx), pkt_id} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = SEND;
      SEND: begin
        if (handshake && is_tail) begin
          if (stop_seen || stop || last_pkt) state_next = DONE;
          else if (gap != 8'd0)              state_next = GAP;
        end
      end
      GAP: begin
        if (stop)                 state_next = DONE;
        else if (gap_cnt <= 8'd1) state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_pkts   <= '0;
      len        <= '0;
      gap        <= '0;
      vclass     <= '0;
      sweep      <= 1'b0;
      cur_x      <= '0;
      cur_y      <= '0;
      flit_idx   <= '0;
      pkt_id     <= '0;
      gap_cnt    <= '0;
      stop_seen  <= 1'b0;
      pkts_sent  <= '0;
      flits_sent <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      num_pkts   <= cfg_num_pkts;
      len        <= len_eff;
      gap        <= cfg_gap;
      vclass     <= cfg_vclass;
      sweep      <= cfg_sweep;
      // Sweep walks the mesh, so bring out-of-range starting points inside it
      cur_x      <= cfg_sweep ? (cfg_dst_x % MX) : cfg_dst_x;
      cur_y      <= cfg_sweep ? (cfg_dst_y % MY) : cfg_dst_y;
      flit_idx   <= '0;
      pkt_id     <= '0;
      gap_cnt    <= '0;
      stop_seen  <= 1'b0;
      pkts_sent  <= '0;
      flits_sent <= '0;
    end else begin
      if (busy && stop) stop_seen <= 1'b1;
      if (handshake) begin
        if (flits_sent != 32'hFFFF_FFFF) flits_sent <= flits_sent + 32'd1;
        if (is_tail) begin
          flit_idx  <= '0;
          pkts_sent <= pkts_inc;
          pkt_id    <= pkt_id + 16'd1;
          gap_cnt   <= gap;
          if (sweep) begin
            if (cur_x >= MX - 8'd1) begin
              cur_x <= '0;
              cur_y <= (cur_y >= MY - 8'd1) ? 8'd0 : cur_y + 8'd1;
            end else begin
              cur_x <= cur_x + 8'd1;
            end
          end
        end else begin
          flit_idx <= flit_idx + LEN_ONE;
        end
      end
      if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/nebula_traffic_gen.md
Name: nebula_traffic_gen

Overview:
Parametrised, synthesizable flit traffic generator that injects multi-flit packets into one router port (normally the local port) through a valid/ready link.
- It replaces single-flit hand-driven stimulus with configurable packet count, length, inter-packet gap, virtual class and destination pattern.
- Used in router and mesh benches, and on-chip as a built-in self-test source.
- Exposes progress counters for scoreboards.

Parameters:
VCS, 2, number of virtual channel classes; VC_W = max(1, $clog2(VCS))
PKT_LEN_MAX, 16, maximum flits per packet; LEN_W = $clog2(PKT_LEN_MAX+1)
MESH_X, 4, mesh X dimension used by sweep mode
MESH_Y, 4, mesh Y dimension used by sweep mode
FLIT_W, $bits(flit_hdr_t)+FLIT_PAYLOAD_W, output flit width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_* and begins a run
stop  in  1  level or pulse; ends the run after the current packet completes
cfg_num_pkts  in  16  packets to send; 0 = unlimited until stop
cfg_pkt_len  in  LEN_W  flits per packet; 0 treated as 1; values >PKT_LEN_MAX clamp to PKT_LEN_MAX
cfg_gap  in  8  idle cycles between a tail handshake and the next head
cfg_vclass  in  VC_W  hdr.vclass for every flit
cfg_dst_x  in  8  destination X (start point in sweep mode)
cfg_dst_y  in  8  destination Y (start point in sweep mode)
cfg_sweep  in  1  0 = fixed destination; 1 = destination advances per packet
out_valid  out  1  flit valid toward router link
out_flit  out  FLIT_W  {flit_hdr_t, payload}
out_ready  in  1  router accepts flit
busy  out  1  run in progress
done  out  1  sticky completion flag; cleared by next start
pkts_sent  out  32  tail handshakes since last start
flits_sent  out  32  flit handshakes since last start

Behaviour:
- Reset (async, immediate): all outputs 0, FSM IDLE, config registers 0. Reset mid-packet drops the packet; no tail is emitted.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE/DONE + start -> SEND.
  - Counters and done clear.
  - busy=1 and out_valid=1 (head flit) from the cycle after start.
- start while busy: ignored.
- SEND: out_flit fields:
  - hdr.head = (flit_idx==0)
  - hdr.tail = (flit_idx==len-1); a len=1 packet has head=tail=1
  - hdr.vclass = cfg_vclass
  - hdr.dst = current {x,y}
  - payload[15:0] = pkt_id; payload[23:16] = flit_idx; remaining payload bits 0
- Handshake is out_valid & out_ready.
  - While out_valid && !out_ready, out_flit is held stable and out_valid stays 1.
  - out_valid never drops mid-packet.
- On each handshake: flits_sent++ and flit_idx++.
- On a tail handshake:
  - pkts_sent++ and pkt_id++ (16-bit, wraps).
  - If stop has been seen, or pkts_sent reaches cfg_num_pkts (nonzero): go to DONE.
  - Else if cfg_gap==0: next head is valid in the next cycle (back-to-back).
  - Else: go to GAP.
- GAP: out_valid=0 for exactly cfg_gap cycles, then SEND. stop during GAP -> DONE immediately.
- stop is latched (stop_seen) whenever asserted in SEND or GAP. Packets are never truncated. stop in IDLE/DONE: no effect.
- DONE: busy=0, done=1, out_valid=0. done stays set until the next start.
- Sweep mode, updated at each tail handshake:
  - x = (x+1) mod MESH_X.
  - When x wraps, y = (y+1) mod MESH_Y.
  - Start values outside the mesh are reduced mod the dimension at start.
- Counters saturate at 2^32-1.
- Simultaneous stop and last-count tail: DONE (same result either way).

Test Plan:
- start with num_pkts=1, len=1, dst=(0,0), vclass=0, ready=1 -> one flit with head=tail=1, payload[23:0]=0, one cycle after start; done=1, pkts_sent=1, flits_sent=1.
- num_pkts=3, len=4, gap=0, ready=1 -> 12 consecutive valid cycles; head at idx 0/4/8, tail at 3/7/11; pkt_id 0,1,2; flits_sent=12.
- len=2, gap=5, num_pkts=2 -> exactly 5 idle cycles between the first tail and the second head.
- ready toggled 1,0,0,1 in a pseudo-random pattern -> flit is stable while stalled; no flit lost or duplicated (scoreboard by pkt_id/flit_idx).
- num_pkts=0, sweep=1, MESH 4x4, start (3,3) -> dst sequence (3,3),(0,0),(1,0)...; stop asserted on flit_idx 1 of len=4 -> that packet completes with its tail, then DONE.
- rst_n low mid-packet -> out_valid=0, busy=0 and counters=0 asynchronously; start after release -> pkt_id restarts at 0.
